argmax_sequencer: RTL

- Sits directly downstream of the PISO output serializer in the NPU output path, and drives its control pins.
- Accepts batches of NUM_TAPS parallel class scores from the output layer via a valid/ready handshake.
- Commands the PISO to load each batch, then to shift it out one word per clock, and consumes the serial DATA_OUT stream.
- Runs a signed running-argmax across NUM_CLASSES scores and reports the winning digit class once per inference.

---
 rtl/argmax_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/argmax_sequencer.sv
// argmax_sequencer: sequences PISO load/shift and runs a signed argmax over the serial scores.
// Define ARGMAX_SCORE_OUT_EN to expose the winning score on MAX_SCORE.
module argmax_sequencer #(
  parameter int WIDTH = 8,
  parameter int NUM_TAPS = 4,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W = 4
) (
  input  logic                    CLKEXT,
  input  logic                    CLR_ARGMAX_N,
  input  logic                    START,
  input  logic                    BATCH_VALID,
  output logic                    BATCH_READY,
  output logic                    SHIFT_OUT,
  output logic                    EN_PISO_OUT,
  input  logic signed [WIDTH-1:0] PISO_DATA,
  output logic                    BUSY,
  output logic                    RESULT_VALID,
`ifdef ARGMAX_SCORE_OUT_EN
  output logic signed [WIDTH-1:0] MAX_SCORE,
`endif
  output logic [IDX_W-1:0]        CLASS_OUT
);
  localparam int NUM_BATCHES = (NUM_CLASSES + NUM_TAPS - 1) / NUM_TAPS;
  typedef enum logic [1:0] {IDLE, WAIT_BATCH, SHIFT, DONE} state_t;
  state_t state;
  logic [IDX_W-1:0] batch_cnt, tap_cnt, idx_r, cur;
  logic signed [WIDTH-1:0] max_r;
  logic have, pad, take, last_tap;
  // The PISO emits its highest tap first, so the class index counts down within a batch.
  assign cur = IDX_W'(int'(batch_cnt) * NUM_TAPS + NUM_TAPS - 1 - int'(tap_cnt));
  assign pad = int'(cur) >= NUM_CLASSES;
  assign take = !pad && (!have || PISO_DATA > max_r || (PISO_DATA == max_r && cur < idx_r));
  assign last_tap = int'(tap_cnt) == NUM_TAPS - 1;
  assign BATCH_READY = state == WAIT_BATCH;
  assign SHIFT_OUT = !(state == WAIT_BATCH && BATCH_VALID);
  assign EN_PISO_OUT = state == SHIFT;
  always_ff @(posedge CLKEXT or negedge CLR_ARGMAX_N) begin
    if (!CLR_ARGMAX_N) begin
      state <= IDLE;
      batch_cnt <= '0;
      tap_cnt <= '0;
      idx_r <= '0;
      max_r <= '0;
      have <= 1'b0;
      BUSY <= 1'b0;
      RESULT_VALID <= 1'b0;
      CLASS_OUT <= '0;
`ifdef ARGMAX_SCORE_OUT_EN
      MAX_SCORE <= '0;
`endif
    end else begin
      RESULT_VALID <= 1'b0;
      case (state)
        IDLE: if (START) begin
          batch_cnt <= '0;
          tap_cnt <= '0;
          have <= 1'b0;
          BUSY <= 1'b1;
          state <= WAIT_BATCH;
        end
        WAIT_BATCH: if (BATCH_VALID) begin
          tap_cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (take) begin
            max_r <= PISO_DATA;
            idx_r <= cur;
            have <= 1'b1;
          end
          tap_cnt <= tap_cnt + IDX_W'(1);
          if (last_tap) begin
            if (int'(batch_cnt) == NUM_BATCHES - 1) state <= DONE;
            else begin
              batch_cnt <= batch_cnt + IDX_W'(1);
              state <= WAIT_BATCH;
            end
          end
        end
        DONE: begin
          RESULT_VALID <= 1'b1;
          CLASS_OUT <= idx_r;
`ifdef ARGMAX_SCORE_OUT_EN
          MAX_SCORE <= max_r;
`endif
          BUSY <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
